// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input, instruction-memory write port and load status of the loader
interface imem_loader_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     load_req;
  logic                     rx_valid;
  logic [7:0]               rx_data;
  logic                     rx_ready;
  logic                     imem_we;
  logic [ADDRESS_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0]    imem_wdata;
  logic                     cpu_hold;
  logic                     load_done;
  logic                     load_err;
  modport master (
    input  load_req, rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
  );
  modport slave (
    output load_req, rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a LEN|words|CSUM byte packet and writes it into instruction memory
module imem_loader #(
  parameter int          ADDRESS_WIDTH = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] BASE_ADDR     = 32'hBFC00000,
  parameter int          MAX_WORDS     = 1024,
  parameter int          HOLD_AT_RESET = 1
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.master bus
);
  localparam int IW = $clog2(MAX_WORDS + 1);
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;
  state_t                   state, next;
  logic [1:0]               byte_cnt;
  logic [23:0]              shift;
  logic [31:0]              len;
  logic [IW-1:0]            word_idx;
  logic [7:0]               csum;
  logic                     we_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     rx_ready, xfer, word_end;
  logic [31:0]              word;
  assign rx_ready = state inside {LEN, DATA, CSUM};
  assign xfer     = bus.rx_valid && rx_ready;
  assign word     = {bus.rx_data, shift};
  assign word_end = xfer && byte_cnt == 2'd3;
  // state register; reset aborts any load in progress
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  // packet sequencing: length check, word count, checksum verdict
  always_comb begin
    next = state;
    unique case (state)
      IDLE, DONE, ERR: next = bus.load_req ? LEN : state;
      LEN:  if (word_end) next = word > 32'(MAX_WORDS) ? ERR : word == 32'd0 ? CSUM : DATA;
      DATA: if (word_end && 32'(word_idx) + 32'd1 == len) next = CSUM;
      CSUM: if (xfer) next = bus.rx_data == csum ? DONE : ERR;
      default: next = IDLE;
    endcase
  end
  // byte assembly, running XOR checksum and the registered memory write port
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      byte_cnt <= '0;
      shift    <= '0;
      len      <= '0;
      word_idx <= '0;
      csum     <= '0;
      we_q     <= 1'b0;
      addr_q   <= ADDRESS_WIDTH'(BASE_ADDR);
      wdata_q  <= '0;
    end else begin
      we_q <= 1'b0;
      if (next == LEN && state != LEN) begin
        byte_cnt <= '0;
        shift    <= '0;
        word_idx <= '0;
        csum     <= '0;
      end else if (xfer && state != CSUM) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= word[31:8];
        csum     <= csum ^ bus.rx_data;
        if (word_end && state == LEN) len <= word;
        if (word_end && state == DATA) begin
          we_q     <= 1'b1;
          addr_q   <= ADDRESS_WIDTH'(BASE_ADDR) + ADDRESS_WIDTH'({word_idx, 2'b00});
          wdata_q  <= DATA_WIDTH'(word);
          word_idx <= word_idx + IW'(1);
        end
      end
    end
  assign bus.rx_ready   = rx_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.load_done  = state == DONE;
  assign bus.load_err   = state == ERR;
  assign bus.cpu_hold   = state == IDLE ? HOLD_AT_RESET != 0 : state != DONE;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random-timing packet loads checked against a packet-level model of the loader
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'hBFC00000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int pass = 0;
  logic [7:0]  pkt[$];
  logic [31:0] exp_a[$], exp_d[$], got_a[$], got_d[$];
  int unsigned blen;
  imem_loader_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();
  imem_loader dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  // every write pulse must match the next write the model predicts
  always @(negedge clk)
    if (!rst && bus.imem_we) begin
      got_a.push_back(bus.imem_addr);
      got_d.push_back(bus.imem_wdata);
      if (exp_a.size() == 0) check("unexpected_we", 1, 0);
      else begin
        check("imem_addr", bus.imem_addr, exp_a.pop_front());
        check("imem_wdata", bus.imem_wdata, exp_d.pop_front());
      end
    end
  task automatic send_byte(input logic [7:0] b, input bit pulse, input bit rv);
    if (rv) while ($urandom_range(0, 2) == 0) begin
      bus.rx_valid = 1'b0;
      @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    bus.load_req = pulse;
    check("rx_ready_in_load", bus.rx_ready, 1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.load_req = 1'b0;
  endtask
  // model: decode the packet by its rules, queue the expected writes, send it, check the verdict
  task automatic run_packet(input int stop, input int pulse_idx, input bit rv);
    int unsigned len;
    bit err_len, done;
    int n;
    logic [7:0] x;
    len = {pkt[3], pkt[2], pkt[1], pkt[0]};
    err_len = len > 1024;
    n = err_len ? 4 : 4 + 4 * int'(len) + 1;
    if (stop >= 0 && stop < n) n = stop;
    x = 8'h00;
    if (!err_len) begin
      for (int i = 0; i < int'(len); i++)
        if (4 + 4 * (i + 1) <= n) begin
          exp_a.push_back(BASE + 32'(4 * i));
          exp_d.push_back({pkt[4*i+7], pkt[4*i+6], pkt[4*i+5], pkt[4*i+4]});
        end
      for (int k = 0; k < 4 + 4 * int'(len); k++) x = x ^ pkt[k];
    end
    @(negedge clk);
    bus.load_req = 1'b1;
    @(negedge clk);
    bus.load_req = 1'b0;
    for (int k = 0; k < n; k++) send_byte(pkt[k], k == pulse_idx, rv);
    if (stop < 0) begin
      repeat (2) @(negedge clk);
      done = !err_len && pkt[4+4*len] == x;
      check("load_done", bus.load_done, done);
      check("load_err", bus.load_err, !done);
      check("cpu_hold", bus.cpu_hold, !done);
      check("rx_ready_after", bus.rx_ready, 0);
      check("writes_pending", exp_a.size(), 0);
    end
  endtask
  task automatic build(input int unsigned len, input bit good);
    logic [7:0] x, b;
    pkt.delete();
    for (int i = 0; i < 4; i++) pkt.push_back(8'(len >> (8 * i)));
    x = 8'(len) ^ 8'(len >> 8) ^ 8'(len >> 16) ^ 8'(len >> 24);
    for (int i = 0; i < 4 * int'(len); i++) begin
      b = 8'($urandom);
      pkt.push_back(b);
      x = x ^ b;
    end
    pkt.push_back(good ? x : x ^ 8'($urandom_range(1, 255)));
    blen = len;
  endtask
  task automatic pin_t1;
    check("t1_nwrites", got_a.size(), 2);
    if (got_a.size() == 2) begin
      check("t1_addr0", got_a[0], 32'hBFC00000);
      check("t1_data0", got_d[0], 32'h00500513);
      check("t1_addr1", got_a[1], 32'hBFC00004);
      check("t1_data1", got_d[1], 32'h0000006F);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bus.load_req = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(negedge clk);
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_we", bus.imem_we, 0);
    check("rst_addr", bus.imem_addr, BASE);
    check("rst_wdata", bus.imem_wdata, 0);
    check("rst_done", bus.load_done, 0);
    check("rst_err", bus.load_err, 0);
    check("rst_hold", bus.cpu_hold, 1);
    rst = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    @(negedge clk);
    check("idle_rx_ready", bus.rx_ready, 0);
    bus.rx_valid = 1'b0;
    // T1
    pkt = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h2B};
    got_a.delete(); got_d.delete();
    run_packet(-1, -1, 0);
    pin_t1();
    check("t1_done_lit", bus.load_done, 1);
    // T2
    pkt[12] = 8'h2A;
    got_a.delete(); got_d.delete();
    run_packet(-1, -1, 0);
    pin_t1();
    check("t2_err_lit", bus.load_err, 1);
    // T3
    pkt = '{8'h01, 8'h04, 8'h00, 8'h00};
    run_packet(-1, -1, 0);
    check("t3_err_lit", bus.load_err, 1);
    // T4
    pkt = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_packet(-1, -1, 0);
    pkt = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    run_packet(-1, -1, 0);
    // T5
    pkt = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h2B};
    got_a.delete(); got_d.delete();
    run_packet(-1, 6, 1);
    pin_t1();
    // T6
    run_packet(9, -1, 0);
    check("t6_pending", exp_a.size(), 0);
    rst = 1'b1;
    #1;
    check("t6_rx_ready", bus.rx_ready, 0);
    check("t6_we", bus.imem_we, 0);
    check("t6_addr", bus.imem_addr, BASE);
    check("t6_wdata", bus.imem_wdata, 0);
    check("t6_done", bus.load_done, 0);
    check("t6_err", bus.load_err, 0);
    check("t6_hold", bus.cpu_hold, 1);
    @(negedge clk);
    rst = 1'b0;
    got_a.delete(); got_d.delete();
    run_packet(-1, -1, 0);
    pin_t1();
    // random images, random valid gaps and a stray load_req inside the data
    for (int r = 0; r < 8; r++) begin
      build($urandom_range(1, 5), 1'($urandom_range(0, 1)));
      run_packet(-1, 4 + int'($urandom_range(0, 4 * blen - 1)), 1);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
